gauss_filter_5x5: RTL and testbench
===================================

// Module: gauss_filter_5x5
// PURPOSE
//  5x5 Gaussian low-pass stage directly downstream of the 5-line buffer.
//  - Input: the current pixel plus the four line-delayed pixels of the same column.
//  - Builds a 5x5 window and applies the separable kernel [1 4 6 4 1]x[1 4 6 4 1] / 256.
//  - Emits one filtered pixel per input pixel, with de/vsync delay-matched for the next ISP stage.
// PARAMETERS
//  DW           8   pixel width in bits.
//  BORDER_MODE  0   0: raw centre pixel when window incomplete; 1: zero when window incomplete.
// PORTS
//  clk      in   1   pixel clock; all logic on rising edge.
//  rst_n    in   1   asynchronous active-low reset.
//  vsync_i  in   1   frame sync, active high.
//  de_i     in   1   pixel valid, high across each active line.
//  tap0_i   in   DW  newest row (current line pixel), aligned with de_i.
//  tap1_i   in   DW  row-1, aligned with de_i.
//  tap2_i   in   DW  row-2, aligned with de_i.
//  tap3_i   in   DW  row-3, aligned with de_i.
//  tap4_i   in   DW  row-4 (oldest), aligned with de_i.
//  vsync_o  out  1   vsync_i delayed 3 cycles.
//  de_o     out  1   de_i delayed 3 cycles.
//  data_o   out  DW  filtered pixel; valid when de_o = 1.
// BEHAVIOUR
//  Reset
//  - Async assert of rst_n clears all state: pipelines, window, counters.
//  - While reset is asserted, vsync_o, de_o and data_o are 0.
//  - Reset mid-line discards the partial line; row_cnt restarts at 0.
//  S1 (when de_i = 1)
//  - v = tap0 + 4*tap1 + 6*tap2 + 4*tap3 + tap4, 12-bit unsigned (max 4080).
//  - v shifts into vs[0..4] (vs[0] newest); tap2_i shifts into ctr[0..4].
//  - When de_i = 0, vs and ctr hold their values.
//  S2 (every cycle)
//  - h = vs[0] + 4*vs[1] + 6*vs[2] + 4*vs[3] + vs[4], registered, 16-bit (max 65280).
//  - ctr[2] and full are registered alongside h.
//  S3 (every cycle)
//  - If full: data_o = (h + 128) >> 8. Max result is 255, so no saturation logic is needed.
//  - If not full: data_o = ctr[2] (BORDER_MODE 0) or 0 (BORDER_MODE 1).
//  - When de_o = 0, data_o = 0.
//  Latency and spatial offset
//  - Latency is exactly 3 cycles: de_o(t+3) = de_i(t).
//  - The window centre is the pixel 2 columns left of and 2 rows above the newest input.
//  - Output pixel count per line equals input pixel count.
//  col_cnt (11 bit)
//  - Cleared in any cycle with de_i = 0.
//  - Otherwise increments, saturating at 2047.
//  - Counts pixels shifted in before the current one.
//  row_cnt (3 bit)
//  - Cleared on vsync_i rising edge.
//  - Increments on de_i falling edge, saturating at 4.
//  - vsync edge and de falling edge in the same cycle: the clear wins.
//  full
//  - full = de_i & (col_cnt >= 4) & (row_cnt >= 4), evaluated in S1.
//  - So the first 4 rows and first 4 columns of each frame/line take the border path.
//  - The window is not flushed between lines: stale columns are masked by the col_cnt condition.
//  Back-to-back frames
//  - vsync_i may arrive with de_i low for a single cycle; no idle gap is required.
// TESTING
//  T1 flat field: 16x16 frame of 100 -> de_o/vsync_o = inputs delayed 3;
//     data_o = 100 everywhere (interior and border).
//  T2 impulse: 255 at input (row 10, col 10) of a 20x20 zero frame.
//     -> data_o = 36 at output (row 12, col 12) [(9180+128)>>8].
//     -> data_o = 24 at (12,11) and (11,12) [(6120+128)>>8].
//     -> data_o = 0 outside rows/cols 10..14.
//  T3 saturation: all-255 frame -> interior data_o = 255, no wrap to small values.
//  T4 border: ramp frame, pixel = col; BORDER_MODE 0.
//     -> rows 0-3 and cols 0-3 of each line output the raw centre tap (tap2 delayed 2 columns).
//     -> repeat with BORDER_MODE 1 -> those positions output 0.
//  T5 reset mid-line: drop rst_n at col 7 of row 6, release after 5 cycles, resume the frame.
//     -> outputs 0 during reset; the next 4 lines take the border path.
//  T6 new frame: vsync_i pulse with de_i low for one cycle between two frames.
//     -> row_cnt restarts; the first 4 lines of frame 2 take the border path; no pixel lost or extra.

Source files
------------

// File: rtl/gauss_filter_5x5.sv
// 5x5 separable Gaussian ([1 4 6 4 1] x [1 4 6 4 1] / 256) fed by a 5-line buffer.
// Three-stage pipeline: vertical sum, horizontal sum, round/border select.
module gauss_filter_5x5 #(
    parameter int DW          = 8,
    parameter int BORDER_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vsync_i,
    input  logic          de_i,
    input  logic [DW-1:0] tap0_i,
    input  logic [DW-1:0] tap1_i,
    input  logic [DW-1:0] tap2_i,
    input  logic [DW-1:0] tap3_i,
    input  logic [DW-1:0] tap4_i,
    output logic          vsync_o,
    output logic          de_o,
    output logic [DW-1:0] data_o
);
    localparam int VW = DW + 4;
    localparam int HW = DW + 8;

    function automatic logic [HW-1:0] wsum(input logic [HW-1:0] a, b, c, d, e);
        return a + (b << 2) + (c << 2) + (c << 1) + (d << 2) + e;
    endfunction

    logic [VW-1:0] vs_q  [5];
    logic [DW-1:0] ctr_q [5];
    logic [VW-1:0] v_d;
    logic [10:0]   col_cnt_q, col_cnt_d;
    logic [2:0]    row_cnt_q, row_cnt_d;
    logic          de_prev_q, vsync_prev_q;
    logic          full_d, full1_q, full2_q;
    logic          de1_q, de2_q, de_o_q;
    logic          vsync1_q, vsync2_q, vsync_o_q;
    logic [HW-1:0] h_d, h_q, rnd_w;
    logic [DW-1:0] c2_q, border_w, data_d, data_q;

    assign v_d = VW'(wsum(HW'(tap0_i), HW'(tap1_i), HW'(tap2_i), HW'(tap3_i), HW'(tap4_i)));

    // Stage 1: window columns advance only on valid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q[0]  <= '0;
            ctr_q[0] <= '0;
        end else if (de_i) begin
            vs_q[0]  <= v_d;
            ctr_q[0] <= tap2_i;
        end
    end

    generate
        for (genvar gi = 1; gi < 5; gi++) begin : g_win
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vs_q[gi]  <= '0;
                    ctr_q[gi] <= '0;
                end else if (de_i) begin
                    vs_q[gi]  <= vs_q[gi-1];
                    ctr_q[gi] <= ctr_q[gi-1];
                end
            end
        end
    endgenerate

    // A vsync rising edge outranks a simultaneous end-of-line.
    always_comb begin
        col_cnt_d = '0;
        if (de_i)
            col_cnt_d = (col_cnt_q == 11'd2047) ? col_cnt_q : col_cnt_q + 11'd1;
        row_cnt_d = row_cnt_q;
        if (vsync_i && !vsync_prev_q)
            row_cnt_d = '0;
        else if (de_prev_q && !de_i && row_cnt_q < 3'd4)
            row_cnt_d = row_cnt_q + 3'd1;
        full_d = de_i && (col_cnt_q >= 11'd4) && (row_cnt_q >= 3'd4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            de_prev_q    <= 1'b0;
            vsync_prev_q <= 1'b0;
            full1_q      <= 1'b0;
            de1_q        <= 1'b0;
            vsync1_q     <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            de_prev_q    <= de_i;
            vsync_prev_q <= vsync_i;
            full1_q      <= full_d;
            de1_q        <= de_i;
            vsync1_q     <= vsync_i;
        end
    end

    // Stage 2: horizontal sum over the five stored vertical sums.
    assign h_d = wsum(HW'(vs_q[0]), HW'(vs_q[1]), HW'(vs_q[2]), HW'(vs_q[3]), HW'(vs_q[4]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= '0;
            c2_q     <= '0;
            full2_q  <= 1'b0;
            de2_q    <= 1'b0;
            vsync2_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            c2_q     <= ctr_q[2];
            full2_q  <= full1_q;
            de2_q    <= de1_q;
            vsync2_q <= vsync1_q;
        end
    end

    // Stage 3: (h + 128) >> 8 cannot exceed the pixel range, so no clamp.
    assign rnd_w    = h_q + HW'(128);
    assign border_w = (BORDER_MODE == 0) ? c2_q : '0;

    always_comb begin
        data_d = '0;
        if (de2_q)
            data_d = full2_q ? rnd_w[HW-1:8] : border_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            de_o_q    <= 1'b0;
            vsync_o_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            de_o_q    <= de2_q;
            vsync_o_q <= vsync2_q;
        end
    end

    assign data_o  = data_q;
    assign de_o    = de_o_q;
    assign vsync_o = vsync_o_q;
endmodule

// File: tb/tb_gauss_filter_5x5.sv
// Bench for gauss_filter_5x5: both border modes driven in parallel from a simple
// edge-replicating line-buffer model; outputs are captured into images and spot-checked.
module tb_gauss_filter_5x5;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, vsync_i, de_i;
    logic [DW-1:0] tap0_i, tap1_i, tap2_i, tap3_i, tap4_i;
    logic          vsync_o0, de_o0, vsync_o1, de_o1;
    logic [DW-1:0] data_o0, data_o1;

    gauss_filter_5x5 #(.DW(DW), .BORDER_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .de_i(de_i),
        .tap0_i(tap0_i), .tap1_i(tap1_i), .tap2_i(tap2_i), .tap3_i(tap3_i), .tap4_i(tap4_i),
        .vsync_o(vsync_o0), .de_o(de_o0), .data_o(data_o0));

    gauss_filter_5x5 #(.DW(DW), .BORDER_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .de_i(de_i),
        .tap0_i(tap0_i), .tap1_i(tap1_i), .tap2_i(tap2_i), .tap3_i(tap3_i), .tap4_i(tap4_i),
        .vsync_o(vsync_o1), .de_o(de_o1), .data_o(data_o1));

    typedef struct {
        int t;
        int r;
        int c;
        int e0;
        int e1;
    } vec_t;
    vec_t tbl[$];

    int total = 0;
    int bad   = 0;
    int img0[32][32];
    int img1[32][32];
    int mrow, mcol, cur_cnt, last_cnt;
    bit lat_en = 1'b0;
    bit de_h[3];
    bit vs_h[3];
    bit pde, pvs;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int t, input int r, input int c, input int e0, input int e1);
        vec_t v;
        v.t = t; v.r = r; v.c = c; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endfunction

    function automatic void clear_img();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                img0[r][c] = -1;
                img1[r][c] = -1;
            end
    endfunction

    // Output capture: rows advance on de_o falling, restart on vsync_o rising or reset.
    initial begin
        mrow = 0; mcol = 0; cur_cnt = 0; last_cnt = 0; pde = 0; pvs = 0;
        clear_img();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mrow = 0; mcol = 0; cur_cnt = 0; pde = 0; pvs = 0;
                clear_img();
                for (int i = 0; i < 3; i++) begin
                    de_h[i] = 1'b0;
                    vs_h[i] = 1'b0;
                end
            end else begin
                if (lat_en) begin
                    check("lat de_o m0", int'(de_o0), int'(de_h[2]));
                    check("lat vsync_o m0", int'(vsync_o0), int'(vs_h[2]));
                    check("lat de_o m1", int'(de_o1), int'(de_h[2]));
                end
                if (vsync_o0 && !pvs) begin
                    mrow = 0; mcol = 0; last_cnt = cur_cnt; cur_cnt = 0;
                    clear_img();
                end else if (!de_o0 && pde) begin
                    mrow++; mcol = 0;
                end
                if (de_o0) begin
                    if (mrow < 32 && mcol < 32) begin
                        img0[mrow][mcol] = int'(data_o0);
                        img1[mrow][mcol] = int'(data_o1);
                    end
                    mcol++; cur_cnt++;
                end
                pde = de_o0; pvs = vsync_o0;
                de_h[2] = de_h[1]; de_h[1] = de_h[0]; de_h[0] = de_i;
                vs_h[2] = vs_h[1]; vs_h[1] = vs_h[0]; vs_h[0] = vsync_i;
            end
        end
    end

    // kind: 0 flat 100, 1 flat 255, 2 ramp (pixel = col), 3 impulse at (10,10)
    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return 255;
            2:       return c;
            default: return (r == 10 && c == 10) ? 255 : 0;
        endcase
    endfunction

    function automatic int tapv(input int kind, input int r, input int c, input int k);
        int rr;
        rr = (r - k < 0) ? 0 : r - k;
        return pix(kind, rr, c);
    endfunction

    task automatic cyc(input bit v, input bit d, input int kind, input int r, input int c);
        vsync_i = v;
        de_i    = d;
        tap0_i  = d ? DW'(tapv(kind, r, c, 0)) : '0;
        tap1_i  = d ? DW'(tapv(kind, r, c, 1)) : '0;
        tap2_i  = d ? DW'(tapv(kind, r, c, 2)) : '0;
        tap3_i  = d ? DW'(tapv(kind, r, c, 3)) : '0;
        tap4_i  = d ? DW'(tapv(kind, r, c, 4)) : '0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic line(input int kind, input int r, input int ncols);
        for (int c = 0; c < ncols; c++) cyc(1'b0, 1'b1, kind, r, c);
    endtask

    task automatic frame(input int kind, input int w, input int h, input int trail);
        cyc(1'b1, 1'b0, 0, 0, 0);
        for (int r = 0; r < h; r++) begin
            line(kind, r, w);
            if (r < h - 1) idle(2);
        end
        idle(trail);
    endtask

    task automatic check_table(input int t);
        foreach (tbl[i]) begin
            if (tbl[i].t == t) begin
                check($sformatf("T%0d m0 (%0d,%0d)", t, tbl[i].r, tbl[i].c),
                      img0[tbl[i].r][tbl[i].c], tbl[i].e0);
                check($sformatf("T%0d m1 (%0d,%0d)", t, tbl[i].r, tbl[i].c),
                      img1[tbl[i].r][tbl[i].c], tbl[i].e1);
            end
        end
    endtask

    initial begin
        // T3 all-255
        add(3, 8, 8, 255, 255);   add(3, 15, 15, 255, 255); add(3, 4, 4, 255, 255);
        add(3, 3, 8, 255, 0);     add(3, 8, 2, 255, 0);     add(3, 10, 0, 255, 0);
        // T4 ramp, stale centre taps come from the previous line's last columns
        add(4, 0, 0, 255, 0);     add(4, 0, 1, 255, 0);     add(4, 0, 2, 0, 0);
        add(4, 2, 9, 7, 0);       add(4, 3, 15, 13, 0);     add(4, 5, 0, 14, 0);
        add(4, 5, 1, 15, 0);      add(4, 5, 3, 1, 0);       add(4, 5, 4, 2, 2);
        add(4, 9, 10, 8, 8);      add(4, 15, 15, 13, 13);
        // T2 impulse 20x20
        add(2, 12, 12, 36, 36);   add(2, 12, 11, 24, 24);   add(2, 11, 12, 24, 24);
        add(2, 13, 13, 16, 16);   add(2, 10, 10, 1, 1);     add(2, 14, 14, 1, 1);
        add(2, 12, 10, 6, 6);     add(2, 9, 12, 0, 0);      add(2, 12, 15, 0, 0);
        add(2, 15, 12, 0, 0);     add(2, 12, 9, 0, 0);      add(2, 19, 19, 0, 0);
        // T6 second of back-to-back flat frames
        add(6, 0, 8, 100, 0);     add(6, 3, 8, 100, 0);     add(6, 4, 3, 100, 0);
        add(6, 4, 4, 100, 100);   add(6, 4, 15, 100, 100);  add(6, 0, 0, 100, 0);
        add(6, 15, 15, 100, 100); add(6, 2, 2, 100, 0);
        // T5 lines after a mid-line reset (ramp)
        add(5, 0, 0, 0, 0);       add(5, 0, 1, 0, 0);       add(5, 0, 5, 3, 0);
        add(5, 1, 0, 14, 0);      add(5, 2, 1, 15, 0);      add(5, 3, 9, 7, 0);
        add(5, 4, 8, 6, 6);       add(5, 4, 3, 1, 0);       add(5, 4, 15, 13, 13);
        add(5, 4, 0, 14, 0);

        rst_n = 1'b0; vsync_i = 1'b0; de_i = 1'b0;
        tap0_i = '0; tap1_i = '0; tap2_i = '0; tap3_i = '0; tap4_i = '0;
        @(negedge clk);
        check("reset de_o", int'(de_o0), 0);
        check("reset vsync_o", int'(vsync_o0), 0);
        check("reset data_o", int'(data_o0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // T1 flat field, two frames so the second has no reset-cleared centre taps
        lat_en = 1'b1;
        frame(0, 16, 16, 4);
        frame(0, 16, 16, 4);
        lat_en = 1'b0;
        check("T1 pixel count", cur_cnt, 256);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                check($sformatf("T1 m0 (%0d,%0d)", r, c), img0[r][c], 100);
                check($sformatf("T1 m1 (%0d,%0d)", r, c), img1[r][c], (r >= 4 && c >= 4) ? 100 : 0);
            end

        frame(1, 16, 16, 4);
        check_table(3);
        frame(2, 16, 16, 4);
        check_table(4);
        frame(3, 20, 20, 4);
        check_table(2);

        // T6 back-to-back frames: vsync cycle is the only gap after the last line
        lat_en = 1'b1;
        frame(0, 16, 16, 0);
        frame(0, 16, 16, 4);
        lat_en = 1'b0;
        check("T6 frame A count", last_cnt, 256);
        check("T6 frame B count", cur_cnt, 256);
        check("T6 frame B rows", mrow, 16);
        check_table(6);

        // T5 reset at col 7 of row 6, then resume rows 7..11
        cyc(1'b1, 1'b0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            line(2, r, 16);
            idle(2);
        end
        line(2, 6, 7);
        rst_n = 1'b0; de_i = 1'b0; vsync_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("T5 reset de_o", int'(de_o0), 0);
            check("T5 reset vsync_o", int'(vsync_o0), 0);
            check("T5 reset data_o", int'(data_o0), 0);
            check("T5 reset data_o m1", int'(data_o1), 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        idle(2);
        for (int r = 7; r < 12; r++) begin
            line(2, r, 16);
            idle(2);
        end
        idle(4);
        check("T5 pixel count", cur_cnt, 80);
        check_table(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
